// File: rtl/css_sched_if.sv
// Bundle between css_sched, its requesters, the response consumer and the
// computation-storage datapath. The slave view belongs to the scheduler.
interface css_sched_if #(
   parameter int NUM_REQ    = 4,
   parameter int mem_width  = 8,
   parameter int mem_length = 8
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0]                 req_ready;
   logic [NUM_REQ-1:0][1:0]            req_cmd;
   logic [NUM_REQ-1:0][mem_length-1:0] req_addA;
   logic [NUM_REQ-1:0][mem_length-1:0] req_addB;
   logic [NUM_REQ-1:0][mem_length-1:0] req_addC;
   logic [NUM_REQ-1:0][mem_width-1:0]  req_data;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [mem_width-1:0]  rsp_data;

   logic                  dp_en;
   logic [1:0]            cmd;
   logic [mem_length-1:0] addA;
   logic [mem_length-1:0] addB;
   logic [mem_length-1:0] addC;
   logic [mem_width-1:0]  DQ_i;
   logic [mem_width-1:0]  DQ_o;

   modport slave (
      input  req_valid, req_cmd, req_addA, req_addB, req_addC, req_data,
      output req_ready,
      output rsp_valid, rsp_id, rsp_data,
      input  rsp_ready,
      output dp_en, cmd, addA, addB, addC, DQ_i,
      input  DQ_o
   );

   modport master (
      output req_valid, req_cmd, req_addA, req_addB, req_addC, req_data,
      input  req_ready,
      input  rsp_valid, rsp_id, rsp_data,
      output rsp_ready,
      input  dp_en, cmd, addA, addB, addC, DQ_i,
      output DQ_o
   );
endinterface

// File: rtl/css_sched.sv
// Round-robin scheduler: one command at a time from NUM_REQ requesters onto a
// shared computation-storage datapath, returning RD/ADD/SUB results tagged by id.
module css_sched #(
   parameter int NUM_REQ    = 4,
   parameter int mem_width  = 8,
   parameter int mem_length = 8,
   parameter int RSP_LAT    = 1
) (
   input logic        clk,
   input logic        rst,
   css_sched_if.slave bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = 3;
   localparam logic [1:0] CMD_WR = 2'b01;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e                state_q, state_d;
   logic [IDW-1:0]        last_q, last_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            cmd_q, cmd_d;
   logic [mem_length-1:0] addA_q, addA_d, addB_q, addB_d, addC_q, addC_d;
   logic [mem_width-1:0]  data_q, data_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [IDW-1:0]        rsp_id_q, rsp_id_d;
   logic [mem_width-1:0]  rsp_data_q, rsp_data_d;

   logic                  gnt_vld;
   logic [IDW-1:0]        gnt_idx;
   logic [IDW-1:0]        cand;
   logic                  accept;

   // Search starts one past the last grant so every requester waits at most NUM_REQ-1 grants.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = IDW'((int'(last_q) + off) % NUM_REQ);
         if (!gnt_vld && bus.req_valid[cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   // Accepting under reset would latch a command the reset is about to drop.
   assign accept = (state_q == IDLE) && gnt_vld && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_q     <= IDW'(NUM_REQ - 1);
         cnt_q      <= '0;
         cmd_q      <= '0;
         addA_q     <= '0;
         addB_q     <= '0;
         addC_q     <= '0;
         data_q     <= '0;
         id_q       <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         cmd_q      <= cmd_d;
         addA_q     <= addA_d;
         addB_q     <= addB_d;
         addC_q     <= addC_d;
         data_q     <= data_d;
         id_q       <= id_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      addA_d     = addA_q;
      addB_d     = addB_q;
      addC_d     = addC_q;
      data_d     = data_q;
      id_d       = id_q;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cmd_d   = bus.req_cmd[gnt_idx];
               addA_d  = bus.req_addA[gnt_idx];
               addB_d  = bus.req_addB[gnt_idx];
               addC_d  = bus.req_addC[gnt_idx];
               data_d  = bus.req_data[gnt_idx];
               id_d    = gnt_idx;
               last_d  = gnt_idx;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (cmd_q == CMD_WR) begin
               state_d = IDLE;
            end else begin
               cnt_d   = CW'(RSP_LAT);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == CW'(1)) begin
               rsp_data_d = bus.DQ_o;
               rsp_id_d   = id_q;
               cnt_d      = '0;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[gnt_idx] = 1'b1;
      bus.dp_en     = (state_q == ISSUE);
      bus.rsp_valid = (state_q == RESP);
      bus.rsp_id    = rsp_id_q;
      bus.rsp_data  = rsp_data_q;
      bus.cmd       = cmd_q;
      bus.addA      = addA_q;
      bus.addB      = addB_q;
      bus.addC      = addC_q;
      bus.DQ_i      = data_q;
   end
endmodule

// File: tb/tb_css_sched.sv
// Scoreboard bench for css_sched with a behavioural computation-storage datapath.
module tb_css_sched;
   localparam int NUM_REQ = 4;
   localparam int MW      = 8;
   localparam int ML      = 8;
   localparam int RSP_LAT = 3;
   localparam logic [1:0] RD = 2'b00, WR = 2'b01, ADD = 2'b10, SUB = 2'b11;

   typedef struct {
      logic [1:0]    id;
      logic [MW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   css_sched_if #(.NUM_REQ(NUM_REQ), .mem_width(MW), .mem_length(ML)) bus ();

   css_sched #(.NUM_REQ(NUM_REQ), .mem_width(MW), .mem_length(ML), .RSP_LAT(RSP_LAT)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Datapath: executes on the dp_en edge, result visible RSP_LAT edges later.
   logic [MW-1:0] dmem [2**ML];
   logic [MW-1:0] pipe [RSP_LAT];
   logic [MW-1:0] dp_res;

   always_comb begin
      dp_res = bus.DQ_i;
      case (bus.cmd)
         RD:      dp_res = dmem[bus.addA];
         ADD:     dp_res = dmem[bus.addA] + dmem[bus.addB];
         SUB:     dp_res = dmem[bus.addA] - dmem[bus.addB];
         default: dp_res = bus.DQ_i;
      endcase
   end

   always @(posedge clk) begin
      if (bus.dp_en && bus.cmd != RD) dmem[bus.addC] <= dp_res;
      pipe[0] <= dp_res;
      for (int k = 1; k < RSP_LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign bus.DQ_o = pipe[RSP_LAT-1];

   int            checks = 0;
   int            errors = 0;
   logic [MW-1:0] ref_mem [2**ML];
   exp_t          exp_q[$];

   task automatic set_lane(input int i, input logic [1:0] c, input logic [7:0] a, b, cc, d);
      bus.req_cmd[i]  = c;
      bus.req_addA[i] = a;
      bus.req_addB[i] = b;
      bus.req_addC[i] = cc;
      bus.req_data[i] = d;
   endtask

   // Reference memory, updated in accept order; pushes expected responses.
   task automatic model_accept(input int i);
      logic [MW-1:0] r;
      exp_t e;
      case (bus.req_cmd[i])
         RD:      r = ref_mem[bus.req_addA[i]];
         ADD:     r = ref_mem[bus.req_addA[i]] + ref_mem[bus.req_addB[i]];
         SUB:     r = ref_mem[bus.req_addA[i]] - ref_mem[bus.req_addB[i]];
         default: r = bus.req_data[i];
      endcase
      if (bus.req_cmd[i] != RD) ref_mem[bus.req_addC[i]] = r;
      if (bus.req_cmd[i] != WR) begin
         e.id   = 2'(i);
         e.data = r;
         exp_q.push_back(e);
      end
   endtask

   // Returns at the negedge of the ISSUE cycle.
   task automatic send(input int i, input logic [1:0] c, input logic [7:0] a, b, cc, d,
                       output bit ok);
      @(negedge clk);
      set_lane(i, c, a, b, cc, d);
      bus.req_valid[i] = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (bus.req_ready[i]) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) model_accept(i);
      @(negedge clk);
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic get_rsp(output bit ok, output logic [1:0] id, output logic [MW-1:0] d,
                          output int lat);
      ok = 1'b0; lat = 0; id = '0; d = '0;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (bus.rsp_valid) begin
            ok = 1'b1; lat = n; id = bus.rsp_id; d = bus.rsp_data;
            break;
         end
         @(negedge clk);
      end
      if (ok) begin
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, RD, 8'h00, 8'h00, 8'h00, 8'h00);
      bus.req_valid = '1;
      repeat (2) begin
         @(negedge clk); #1;
         checks++;
         if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.dp_en !== 1'b0)
            begin errors++; $display("FAIL reset_hs ready=%b rsp_valid=%b dp_en=%b want 0000/0/0",
                                     bus.req_ready, bus.rsp_valid, bus.dp_en); end
      end
      checks++;
      if (bus.cmd !== 2'b00 || bus.addA !== 8'h00 || bus.addB !== 8'h00 || bus.addC !== 8'h00 ||
          bus.DQ_i !== 8'h00 || bus.rsp_id !== 2'd0 || bus.rsp_data !== 8'h00)
         begin errors++; $display("FAIL reset_regs cmd=%b A=%h B=%h C=%h DQ_i=%h id=%0d data=%h want all 0",
                                  bus.cmd, bus.addA, bus.addB, bus.addC, bus.DQ_i, bus.rsp_id, bus.rsp_data); end
      rst = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001)
         begin errors++; $display("FAIL reset_first_grant ready=%b want 0001", bus.req_ready); end
      bus.req_valid = '0;
   endtask

   task automatic test_wr_rd;
      bit ok; logic [1:0] id; logic [MW-1:0] d; int lat; exp_t e;
      send(1, WR, 8'h00, 8'h00, 8'h00, 8'hAA, ok);
      #1;
      checks++;
      if (!ok || bus.dp_en !== 1'b1 || bus.cmd !== WR || bus.addC !== 8'h00 || bus.DQ_i !== 8'hAA)
         begin errors++; $display("FAIL wr_issue ok=%0d dp_en=%b cmd=%b C=%h DQ_i=%h want 1/1/01/00/aa",
                                  ok, bus.dp_en, bus.cmd, bus.addC, bus.DQ_i); end
      repeat (4) begin
         @(negedge clk); #1;
         checks++;
         if (bus.dp_en !== 1'b0 || bus.rsp_valid !== 1'b0)
            begin errors++; $display("FAIL wr_quiet dp_en=%b rsp_valid=%b want 0/0", bus.dp_en, bus.rsp_valid); end
      end
      send(1, RD, 8'h00, 8'h00, 8'h00, 8'h00, ok);
      #1;
      checks++;
      if (!ok || bus.dp_en !== 1'b1 || bus.cmd !== RD || bus.addA !== 8'h00)
         begin errors++; $display("FAIL rd_issue ok=%0d dp_en=%b cmd=%b A=%h want 1/1/00/00",
                                  ok, bus.dp_en, bus.cmd, bus.addA); end
      get_rsp(ok, id, d, lat);
      checks++;
      if (!ok || lat !== RSP_LAT + 1)
         begin errors++; $display("FAIL rd_latency ok=%0d lat=%0d want %0d", ok, lat, RSP_LAT + 1); end
      e = exp_q.pop_front();
      checks++;
      if (id !== e.id || d !== e.data || id !== 2'd1 || d !== 8'hAA)
         begin errors++; $display("FAIL rd_data id=%0d data=%h want 1/aa (sb %0d/%h)", id, d, e.id, e.data); end
   endtask

   task automatic test_add_sub;
      bit ok; logic [1:0] id; logic [MW-1:0] d; int lat; exp_t e;
      send(2, WR, 8'h00, 8'h00, 8'h00, 8'hAA, ok);
      send(2, WR, 8'h00, 8'h00, 8'h01, 8'hAB, ok);
      send(2, ADD, 8'h00, 8'h01, 8'h04, 8'h00, ok);
      get_rsp(ok, id, d, lat);
      e = exp_q.pop_front();
      checks++;
      if (!ok || id !== e.id || d !== e.data || d !== 8'h55)
         begin errors++; $display("FAIL add ok=%0d id=%0d data=%h want 2/55", ok, id, d); end
      send(3, SUB, 8'h00, 8'h01, 8'h04, 8'h00, ok);
      get_rsp(ok, id, d, lat);
      e = exp_q.pop_front();
      checks++;
      if (!ok || id !== e.id || d !== e.data || d !== 8'hFF || id !== 2'd3)
         begin errors++; $display("FAIL sub_wrap ok=%0d id=%0d data=%h want 3/ff", ok, id, d); end
   endtask

   task automatic test_fairness;
      logic [7:0] addr_tbl [4];
      bit got; int gi; exp_t e;
      addr_tbl = '{8'h00, 8'h01, 8'h04, 8'h00};
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, RD, addr_tbl[i], 8'h00, 8'h00, 8'h00);
      bus.req_valid = '1;
      bus.rsp_ready = 1'b1;
      for (int g = 0; g < 6; g++) begin
         got = 1'b0; gi = -1;
         for (int n = 0; n < 40; n++) begin
            #1;
            checks++;
            if ($countones(bus.req_ready) > 1)
               begin errors++; $display("FAIL two_hot ready=%b want one-hot", bus.req_ready); end
            if (|bus.req_ready) begin got = 1'b1; break; end
            @(negedge clk);
         end
         for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) gi = i;
         checks++;
         if (!got || gi != g % NUM_REQ)
            begin errors++; $display("FAIL grant_order n=%0d got=%0d want %0d", g, gi, g % NUM_REQ); end
         if (got) model_accept(gi);
         @(negedge clk);
         got = 1'b0;
         for (int n = 0; n < 40; n++) begin
            #1;
            if (bus.rsp_valid) begin got = 1'b1; break; end
            @(negedge clk);
         end
         checks++;
         if (!got || exp_q.size() == 0)
            begin errors++; $display("FAIL fair_rsp_timeout n=%0d valid=%b want 1", g, bus.rsp_valid); end
         else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rsp_id !== e.id || bus.rsp_data !== e.data)
               begin errors++; $display("FAIL fair_rsp id=%0d data=%h want %0d/%h",
                                        bus.rsp_id, bus.rsp_data, e.id, e.data); end
         end
         if (g == 5) bus.req_valid = '0;
         @(negedge clk);
      end
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      bit ok; bit got; logic [1:0] id0; logic [MW-1:0] d0; exp_t e;
      send(0, RD, 8'h04, 8'h00, 8'h00, 8'h00, ok);
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (bus.rsp_valid) begin got = 1'b1; break; end
         @(negedge clk);
      end
      id0 = bus.rsp_id; d0 = bus.rsp_data;
      e = exp_q.pop_front();
      checks++;
      if (!ok || !got || id0 !== e.id || d0 !== e.data || d0 !== 8'hFF || id0 !== 2'd0)
         begin errors++; $display("FAIL bp_rsp got=%0d id=%0d data=%h want 0/ff", got, id0, d0); end
      set_lane(1, WR, 8'h00, 8'h00, 8'h08, 8'h3C);
      bus.req_valid[1] = 1'b1;
      repeat (10) begin
         @(negedge clk); #1;
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== id0 || bus.rsp_data !== d0 ||
             bus.req_ready !== 4'b0000 || bus.dp_en !== 1'b0)
            begin errors++; $display("FAIL bp_hold valid=%b id=%0d data=%h ready=%b dp_en=%b want 1/%0d/%h/0000/0",
                                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.req_ready, bus.dp_en, id0, d0); end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0010)
         begin errors++; $display("FAIL bp_release ready=%b want 0010", bus.req_ready); end
      if (bus.req_ready[1]) model_accept(1);
      @(negedge clk);
      bus.req_valid[1] = 1'b0;
      #1;
      checks++;
      if (bus.dp_en !== 1'b1 || bus.cmd !== WR || bus.addC !== 8'h08 || bus.DQ_i !== 8'h3C)
         begin errors++; $display("FAIL bp_next_issue dp_en=%b cmd=%b C=%h DQ_i=%h want 1/01/08/3c",
                                  bus.dp_en, bus.cmd, bus.addC, bus.DQ_i); end
   endtask

   task automatic test_reset_mid_wait;
      bit ok;
      send(2, RD, 8'h00, 8'h00, 8'h00, 8'h00, ok);
      if (ok) exp_q.delete(exp_q.size() - 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (!ok || bus.dp_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000)
         begin errors++; $display("FAIL mid_wait_reset ok=%0d dp_en=%b valid=%b ready=%b want 1/0/0/0000",
                                  ok, bus.dp_en, bus.rsp_valid, bus.req_ready); end
      bus.rsp_ready = 1'b1;
      repeat (8) begin
         @(negedge clk); #1;
         checks++;
         if (bus.rsp_valid !== 1'b0)
            begin errors++; $display("FAIL aborted_rsp valid=%b want 0", bus.rsp_valid); end
      end
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, RD, 8'h00, 8'h00, 8'h00, 8'h00);
      bus.req_valid = '1;
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001)
         begin errors++; $display("FAIL post_reset_grant ready=%b want 0001", bus.req_ready); end
      bus.req_valid = '0;
      checks++;
      if (exp_q.size() != 0)
         begin errors++; $display("FAIL sb_leftover size=%0d want 0", exp_q.size()); end
   endtask

   initial begin
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, RD, 8'h00, 8'h00, 8'h00, 8'h00);
      test_reset;
      test_wr_rd;
      test_add_sub;
      test_fairness;
      test_backpressure;
      test_reset_mid_wait;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
